// File: rtl/ml_engine_rf_seq_if.sv
// Handshake and configuration bundle for the random-forest classifier.
// The engine takes the slave modport; the feeding/consuming side takes master.
interface ml_engine_rf_seq_if #(
  parameter int NUM_FEATURES   = 9,
  parameter int FEAT_W         = 16,
  parameter int NUM_TREES      = 5,
  parameter int NODES_PER_TREE = 64
);
  localparam int ADDR_W = $clog2(NUM_TREES * NODES_PER_TREE);
  localparam int CFG_W  = 1 + $clog2(NUM_FEATURES) + FEAT_W + $clog2(NODES_PER_TREE) + 2;

  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_FEATURES*FEAT_W-1:0] features;
  logic                           cfg_we;
  logic [ADDR_W-1:0]              cfg_addr;
  logic [CFG_W-1:0]               cfg_wdata;
  logic                           cfg_err;
  logic                           out_valid;
  logic                           out_ready;
  logic [1:0]                     final_action;
  logic [1:0]                     ml_vote;
  logic                           rule_override;
  logic                           depth_err;

  modport master (
    output in_valid, features, cfg_we, cfg_addr, cfg_wdata, out_ready,
    input  in_ready, cfg_err, out_valid, final_action, ml_vote, rule_override, depth_err
  );

  modport slave (
    input  in_valid, features, cfg_we, cfg_addr, cfg_wdata, out_ready,
    output in_ready, cfg_err, out_valid, final_action, ml_vote, rule_override, depth_err
  );
endinterface

// File: rtl/ml_engine_rf_seq.sv
// Table-driven random-forest classifier: walks one node per cycle from a
// programmable node memory, then merges the forest vote with expert rules.
//
//   state | meaning
//   IDLE  | ready for a feature vector; node memory writable
//   WALK  | visit one node of the current tree per cycle
//   VOTE  | majority vote + expert rules, register results
//   DONE  | result held on out_valid until out_ready
module ml_engine_rf_seq #(
  parameter int NUM_FEATURES   = 9,
  parameter int FEAT_W         = 16,
  parameter int NUM_TREES      = 5,
  parameter int NODES_PER_TREE = 64,
  parameter int MAX_DEPTH      = 8,
  parameter int ROW_HIT_TH     = 64,
  parameter int RATIO_MUL      = 5,
  parameter int RATE_TH        = 50,
  parameter int COL_TH         = 8
) (
  input logic clk,
  input logic rst_n,
  ml_engine_rf_seq_if.slave bus
);
  localparam int FI_W      = $clog2(NUM_FEATURES);
  localparam int NODE_W    = $clog2(NODES_PER_TREE);
  localparam int MEM_DEPTH = NUM_TREES * NODES_PER_TREE;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);
  localparam int CFG_W     = 1 + FI_W + FEAT_W + NODE_W + 2;
  localparam int TREE_W    = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;
  localparam int DEP_W     = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int CNT_W     = $clog2(NUM_TREES + 1);
  localparam int PROD_W    = FEAT_W + 8;

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_VOTE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [FEAT_W-1:0]      feat_q [NUM_FEATURES];
  logic [FEAT_W-1:0]      feat_d [NUM_FEATURES];
  logic [TREE_W-1:0]      tree_q, tree_d;
  logic [NODE_W-1:0]      node_q, node_d;
  logic [DEP_W-1:0]       depth_q, depth_d;
  logic [CNT_W-1:0]       cnt0_q, cnt0_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic                   derr_acc_q, derr_acc_d;
  logic                   out_valid_q, out_valid_d;
  logic [1:0]             final_action_q, final_action_d;
  logic [1:0]             ml_vote_q, ml_vote_d;
  logic                   rule_override_q, rule_override_d;
  logic                   depth_err_q, depth_err_d;
  logic                   cfg_err_q, cfg_err_d;

  logic [CFG_W-1:0]       node_mem [MEM_DEPTH];
  logic [CFG_W-1:0]       node_word;
  logic                   n_leaf;
  logic [FI_W-1:0]        n_feat;
  logic [FEAT_W-1:0]      n_thr;
  logic [NODE_W-1:0]      n_child;
  logic [1:0]             n_cls;
  logic [FEAT_W-1:0]      feat_val;
  logic [1:0]             vote_cls;
  logic [1:0]             maj_vote;
  logic [1:0]             rule_act;
  logic [PROD_W-1:0]      row_prod;
  logic                   scrub_hit, refresh_hit;

  // Node memory has no reset; software reloads it after power-up.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && state_q == S_IDLE && int'(bus.cfg_addr) < MEM_DEPTH)
      node_mem[bus.cfg_addr] <= bus.cfg_wdata;
  end

  assign node_word = node_mem[ADDR_W'({tree_q, node_q})];
  assign n_leaf    = node_word[CFG_W-1];
  assign n_feat    = node_word[CFG_W-2 -: FI_W];
  assign n_thr     = node_word[2+NODE_W +: FEAT_W];
  assign n_child   = node_word[2 +: NODE_W];
  assign n_cls     = node_word[1:0];

  always_comb begin
    feat_val = '0;
    for (int i = 0; i < NUM_FEATURES; i++)
      if (n_feat == FI_W'(i)) feat_val = feat_q[i];
  end

  // Slots: 0 total_errors, 4 unique_rows, 5 unique_cols, 6 max_row_hits, 8 error_rate_int.
  always_comb begin
    row_prod    = PROD_W'(feat_q[4]) * PROD_W'(RATIO_MUL);
    scrub_hit   = (feat_q[6] >= FEAT_W'(ROW_HIT_TH)) || (row_prod < PROD_W'(feat_q[0]));
    refresh_hit = (feat_q[8] >= FEAT_W'(RATE_TH)) && (feat_q[5] >= FEAT_W'(COL_TH));
    rule_act    = scrub_hit ? 2'd1 : (refresh_hit ? 2'd2 : 2'd0);
    if (cnt1_q >= cnt0_q && cnt1_q >= cnt2_q)      maj_vote = 2'd1;
    else if (cnt2_q >= cnt0_q && cnt2_q >= cnt1_q) maj_vote = 2'd2;
    else                                           maj_vote = 2'd0;
  end

  always_comb begin
    state_d         = state_q;
    feat_d          = feat_q;
    tree_d          = tree_q;
    node_d          = node_q;
    depth_d         = depth_q;
    cnt0_d          = cnt0_q;
    cnt1_d          = cnt1_q;
    cnt2_d          = cnt2_q;
    derr_acc_d      = derr_acc_q;
    out_valid_d     = out_valid_q;
    final_action_d  = final_action_q;
    ml_vote_d       = ml_vote_q;
    rule_override_d = rule_override_q;
    depth_err_d     = depth_err_q;
    cfg_err_d       = bus.cfg_we && (state_q != S_IDLE);
    vote_cls        = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          for (int i = 0; i < NUM_FEATURES; i++)
            feat_d[i] = bus.features[i*FEAT_W +: FEAT_W];
          tree_d     = '0;
          node_d     = '0;
          depth_d    = '0;
          cnt0_d     = '0;
          cnt1_d     = '0;
          cnt2_d     = '0;
          derr_acc_d = 1'b0;
          state_d    = S_WALK;
        end
      end
      S_WALK: begin
        // A tree ends on a leaf or when its depth budget runs out (forced class 0).
        if (n_leaf || depth_q == DEP_W'(MAX_DEPTH - 1)) begin
          vote_cls = (n_leaf && n_cls != 2'd3) ? n_cls : 2'd0;
          case (vote_cls)
            2'd1:    cnt1_d = cnt1_q + CNT_W'(1);
            2'd2:    cnt2_d = cnt2_q + CNT_W'(1);
            default: cnt0_d = cnt0_q + CNT_W'(1);
          endcase
          if (!n_leaf) derr_acc_d = 1'b1;
          node_d  = '0;
          depth_d = '0;
          if (tree_q == TREE_W'(NUM_TREES - 1)) state_d = S_VOTE;
          else                                  tree_d  = tree_q + TREE_W'(1);
        end else begin
          node_d  = (feat_val <= n_thr) ? n_child : n_child + NODE_W'(1);
          depth_d = depth_q + DEP_W'(1);
        end
      end
      S_VOTE: begin
        ml_vote_d       = maj_vote;
        final_action_d  = (rule_act != 2'd0) ? rule_act : maj_vote;
        rule_override_d = (rule_act != 2'd0);
        depth_err_d     = derr_acc_q;
        out_valid_d     = 1'b1;
        state_d         = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      feat_q          <= '{default: '0};
      tree_q          <= '0;
      node_q          <= '0;
      depth_q         <= '0;
      cnt0_q          <= '0;
      cnt1_q          <= '0;
      cnt2_q          <= '0;
      derr_acc_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      final_action_q  <= 2'd0;
      ml_vote_q       <= 2'd0;
      rule_override_q <= 1'b0;
      depth_err_q     <= 1'b0;
      cfg_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      feat_q          <= feat_d;
      tree_q          <= tree_d;
      node_q          <= node_d;
      depth_q         <= depth_d;
      cnt0_q          <= cnt0_d;
      cnt1_q          <= cnt1_d;
      cnt2_q          <= cnt2_d;
      derr_acc_q      <= derr_acc_d;
      out_valid_q     <= out_valid_d;
      final_action_q  <= final_action_d;
      ml_vote_q       <= ml_vote_d;
      rule_override_q <= rule_override_d;
      depth_err_q     <= depth_err_d;
      cfg_err_q       <= cfg_err_d;
    end
  end

  assign bus.in_ready      = (state_q == S_IDLE);
  assign bus.out_valid     = out_valid_q;
  assign bus.final_action  = final_action_q;
  assign bus.ml_vote       = ml_vote_q;
  assign bus.rule_override = rule_override_q;
  assign bus.depth_err     = depth_err_q;
  assign bus.cfg_err       = cfg_err_q;
endmodule

// File: tb/tb_ml_engine_rf_seq.sv
// Directed bench for ml_engine_rf_seq: forest voting, expert overrides,
// node-walk latency, depth limit, config-write gating and reset abort.
module tb_ml_engine_rf_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [8:0][15:0] fv;

  ml_engine_rf_seq_if #(.NUM_FEATURES(9), .FEAT_W(16), .NUM_TREES(5), .NODES_PER_TREE(64)) bus ();

  ml_engine_rf_seq #(
    .NUM_FEATURES(9), .FEAT_W(16), .NUM_TREES(5), .NODES_PER_TREE(64), .MAX_DEPTH(8),
    .ROW_HIT_TH(64), .RATIO_MUL(5), .RATE_TH(50), .COL_TH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [28:0] leaf(input logic [1:0] cls);
    return {1'b1, 4'd0, 16'd0, 6'd0, cls};
  endfunction

  function automatic logic [28:0] inode(input logic [3:0] feat, input logic [15:0] thr, input logic [5:0] child);
    return {1'b0, feat, thr, child, 2'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int tree, input int node, input logic [28:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 9'(tree * 64 + node);
    bus.cfg_wdata = d;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic load_roots(input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2,
                            input logic [1:0] c3, input logic [1:0] c4);
    wr(0, 0, leaf(c0));
    wr(1, 0, leaf(c1));
    wr(2, 0, leaf(c2));
    wr(3, 0, leaf(c3));
    wr(4, 0, leaf(c4));
  endtask

  task automatic start();
    bus.features = fv;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    while (bus.out_valid !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_tests++; if (bus.final_action !== 2'd0) begin n_fail++; $display("FAIL reset_final_action: got %0d expected 0", bus.final_action); end
    n_tests++; if (bus.ml_vote !== 2'd0) begin n_fail++; $display("FAIL reset_ml_vote: got %0d expected 0", bus.ml_vote); end
    n_tests++; if (bus.rule_override !== 1'b0) begin n_fail++; $display("FAIL reset_rule_override: got %b expected 0", bus.rule_override); end
    n_tests++; if (bus.depth_err !== 1'b0) begin n_fail++; $display("FAIL reset_depth_err: got %b expected 0", bus.depth_err); end
    n_tests++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b expected 0", bus.cfg_err); end
  endtask

  task automatic test_all_leaf();
    int cyc;
    load_roots(1, 1, 1, 1, 1);
    fv = '0;
    start();
    wait_done(1, cyc);
    n_tests++; if (cyc != 7) begin n_fail++; $display("FAIL leaf_latency: got %0d expected 7", cyc); end
    n_tests++; if (bus.ml_vote !== 2'd1) begin n_fail++; $display("FAIL leaf_ml_vote: got %0d expected 1", bus.ml_vote); end
    n_tests++; if (bus.final_action !== 2'd1) begin n_fail++; $display("FAIL leaf_final: got %0d expected 1", bus.final_action); end
    n_tests++; if (bus.rule_override !== 1'b0) begin n_fail++; $display("FAIL leaf_override: got %b expected 0", bus.rule_override); end
    n_tests++; if (bus.depth_err !== 1'b0) begin n_fail++; $display("FAIL leaf_depth_err: got %b expected 0", bus.depth_err); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL leaf_in_ready_done: got %b expected 0", bus.in_ready); end
    accept();
    n_tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL leaf_after_accept: in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_tie();
    int cyc;
    load_roots(0, 0, 1, 1, 2);
    fv = '0;
    fv[4] = 16'd10;
    fv[0] = 16'd20;
    start();
    wait_done(1, cyc);
    n_tests++; if (cyc != 7) begin n_fail++; $display("FAIL tie_latency: got %0d expected 7", cyc); end
    n_tests++; if (bus.ml_vote !== 2'd1) begin n_fail++; $display("FAIL tie_ml_vote: got %0d expected 1", bus.ml_vote); end
    n_tests++; if (bus.final_action !== 2'd1 || bus.rule_override !== 1'b0) begin n_fail++; $display("FAIL tie_final: got %0d/%b expected 1/0", bus.final_action, bus.rule_override); end
    accept();
  endtask

  typedef struct {
    int f0, f4, f5, f6, f8;
    int exp_final, exp_ovr;
  } rule_vec_t;

  task automatic test_rules();
    int cyc;
    rule_vec_t tbl [7];
    tbl = '{
      '{0,      0,      0, 64, 0,  1, 1},
      '{0,      0,      0, 63, 0,  0, 0},
      '{20,     4,      8, 0,  50, 2, 1},
      '{20,     4,      8, 0,  49, 0, 0},
      '{20,     4,      7, 0,  50, 0, 0},
      '{16,     3,      0, 0,  0,  1, 1},
      '{'hFFFF, 'h3400, 0, 0,  0,  0, 0}
    };
    load_roots(0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      fv = '0;
      fv[0] = 16'(tbl[i].f0);
      fv[4] = 16'(tbl[i].f4);
      fv[5] = 16'(tbl[i].f5);
      fv[6] = 16'(tbl[i].f6);
      fv[8] = 16'(tbl[i].f8);
      start();
      wait_done(1, cyc);
      n_tests++; if (cyc != 7 || bus.ml_vote !== 2'd0) begin n_fail++; $display("FAIL rules_%0d_vote: cyc=%0d vote=%0d expected 7/0", i, cyc, bus.ml_vote); end
      n_tests++; if (bus.final_action !== 2'(tbl[i].exp_final) || bus.rule_override !== 1'(tbl[i].exp_ovr)) begin
        n_fail++; $display("FAIL rules_%0d_action: got %0d/%b expected %0d/%0d", i, bus.final_action, bus.rule_override, tbl[i].exp_final, tbl[i].exp_ovr);
      end
      accept();
    end
  endtask

  typedef struct {
    int thr, f3, mid_cls, exp_vote;
  } path_vec_t;

  task automatic test_internal();
    int cyc;
    path_vec_t tbl [6];
    tbl = '{'{4, 4, 0, 0}, '{3, 4, 0, 0}, '{4, 4, 2, 2}, '{3, 4, 2, 0}, '{4, 5, 2, 0}, '{4, 3, 2, 2}};
    for (int i = 0; i < 6; i++) begin
      load_roots(0, 2'(tbl[i].mid_cls), 2'(tbl[i].mid_cls), 0, 0);
      wr(0, 0, inode(4'd3, 16'(tbl[i].thr), 6'd1));
      wr(0, 1, leaf(2));
      wr(0, 2, leaf(0));
      fv = '0;
      fv[3] = 16'(tbl[i].f3);
      start();
      wait_done(1, cyc);
      n_tests++; if (cyc != 8) begin n_fail++; $display("FAIL path_%0d_latency: got %0d expected 8", i, cyc); end
      n_tests++; if (bus.ml_vote !== 2'(tbl[i].exp_vote) || bus.final_action !== 2'(tbl[i].exp_vote)) begin
        n_fail++; $display("FAIL path_%0d_vote: got %0d/%0d expected %0d", i, bus.ml_vote, bus.final_action, tbl[i].exp_vote);
      end
      accept();
    end
  endtask

  task automatic test_oob_feat();
    int cyc;
    load_roots(0, 1, 1, 0, 0);
    wr(0, 0, inode(4'd12, 16'd0, 6'd1));
    wr(0, 1, leaf(1));
    wr(0, 2, leaf(0));
    fv = '1;
    start();
    wait_done(1, cyc);
    n_tests++; if (cyc != 8 || bus.ml_vote !== 2'd1) begin n_fail++; $display("FAIL oob_feat: cyc=%0d vote=%0d expected 8/1", cyc, bus.ml_vote); end
    n_tests++; if (bus.final_action !== 2'd1 || bus.rule_override !== 1'b1) begin n_fail++; $display("FAIL oob_feat_rule: got %0d/%b expected 1/1", bus.final_action, bus.rule_override); end
    accept();
  endtask

  task automatic test_self_loop();
    int cyc;
    load_roots(0, 1, 1, 0, 0);
    wr(0, 0, inode(4'd0, 16'hFFFF, 6'd0));
    fv = '0;
    start();
    wait_done(1, cyc);
    n_tests++; if (cyc != 14) begin n_fail++; $display("FAIL loop_latency: got %0d expected 14", cyc); end
    n_tests++; if (bus.depth_err !== 1'b1) begin n_fail++; $display("FAIL loop_depth_err: got %b expected 1", bus.depth_err); end
    n_tests++; if (bus.ml_vote !== 2'd0) begin n_fail++; $display("FAIL loop_vote: got %0d expected 0", bus.ml_vote); end
    accept();
    wr(0, 0, leaf(1));
    start();
    wait_done(1, cyc);
    n_tests++; if (cyc != 7 || bus.depth_err !== 1'b0 || bus.ml_vote !== 2'd1) begin
      n_fail++; $display("FAIL loop_clear: cyc=%0d depth_err=%b vote=%0d expected 7/0/1", cyc, bus.depth_err, bus.ml_vote);
    end
    accept();
  endtask

  task automatic test_hold_cfg();
    int cyc;
    load_roots(1, 1, 1, 0, 0);
    fv = '0;
    start();
    wr(0, 0, leaf(0));
    n_tests++; if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_walk: got %b expected 1", bus.cfg_err); end
    tick();
    n_tests++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_pulse: got %b expected 0", bus.cfg_err); end
    wait_done(3, cyc);
    n_tests++; if (cyc != 7 || bus.ml_vote !== 2'd1) begin n_fail++; $display("FAIL hold_result: cyc=%0d vote=%0d expected 7/1", cyc, bus.ml_vote); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.ml_vote !== 2'd1 || bus.final_action !== 2'd1 || bus.rule_override !== 1'b0) begin
        n_fail++; $display("FAIL hold_%0d: valid=%b ready=%b vote=%0d final=%0d expected 1/0/1/1", i, bus.out_valid, bus.in_ready, bus.ml_vote, bus.final_action);
      end
    end
    wr(0, 0, leaf(0));
    n_tests++; if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_done: got %b expected 1", bus.cfg_err); end
    accept();
    start();
    wait_done(1, cyc);
    n_tests++; if (cyc != 7 || bus.ml_vote !== 2'd1) begin n_fail++; $display("FAIL cfg_dropped: cyc=%0d vote=%0d expected 7/1", cyc, bus.ml_vote); end
    accept();
  endtask

  task automatic test_same_cycle();
    int cyc;
    load_roots(0, 2, 2, 0, 0);
    fv = '0;
    bus.features  = fv;
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 9'd0;
    bus.cfg_wdata = leaf(2);
    bus.in_valid  = 1'b1;
    tick();
    bus.cfg_we    = 1'b0;
    bus.in_valid  = 1'b0;
    wait_done(1, cyc);
    n_tests++; if (cyc != 7 || bus.ml_vote !== 2'd2) begin n_fail++; $display("FAIL same_cycle_write: cyc=%0d vote=%0d expected 7/2", cyc, bus.ml_vote); end
    n_tests++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL same_cycle_cfg_err: got %b expected 0", bus.cfg_err); end
    accept();
  endtask

  task automatic test_reset_mid_walk();
    int cyc;
    int bad;
    load_roots(0, 1, 1, 0, 0);
    wr(0, 0, inode(4'd0, 16'hFFFF, 6'd0));
    fv = '0;
    start();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset: in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL mid_reset_quiet: got %0d bad cycles expected 0", bad); end
    wr(0, 0, leaf(1));
    start();
    wait_done(1, cyc);
    n_tests++; if (cyc != 7 || bus.ml_vote !== 2'd1 || bus.depth_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_restart: cyc=%0d vote=%0d depth_err=%b expected 7/1/0", cyc, bus.ml_vote, bus.depth_err);
    end
    accept();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.features  = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.out_ready = 1'b0;
    fv = '0;
    test_reset();
    test_all_leaf();
    test_tie();
    test_rules();
    test_internal();
    test_oob_feat();
    test_self_loop();
    test_hold_cfg();
    test_same_cycle();
    test_reset_mid_walk();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ml_engine_rf_seq.md
# ml_engine_rf_seq

Sequential, table-driven random-forest classifier for the DRAM error-telemetry path. It replaces hard-wired comparator trees with a programmable node memory, walked one node per cycle. Tree count, depth, feature width and feature count are parametrised. A valid/ready handshake sits on input and output. It keeps the parallel expert-rule safety layer (SCRUB/REFRESH override) and reports which path decided the action.

## Interface
- NUM_FEATURES, 9, feature slots; fixed order 0 total_errors, 1 read_errors, 2 write_errors, 3 scrub_errors, 4 unique_rows, 5 unique_cols, 6 max_row_hits, 7 max_col_hits, 8 error_rate_int
- FEAT_W, 16, bits per feature, unsigned
- NUM_TREES, 5, trees in forest (1..15)
- NODES_PER_TREE, 64, node slots per tree (power of 2)
- MAX_DEPTH, 8, max nodes visited per tree, leaf included
- ROW_HIT_TH, 64; RATIO_MUL, 5; RATE_TH, 50; COL_TH, 8: expert-rule constants
- Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  feature vector valid
- in_ready  out  1  engine can accept a vector
- features  in  NUM_FEATURES*FEAT_W  packed; slot i at [i*FEAT_W +: FEAT_W]
- cfg_we  in  1  node-memory write strobe
- cfg_addr  in  $clog2(NUM_TREES*NODES_PER_TREE)  tree*NODES_PER_TREE + node
- cfg_wdata  in  1+$clog2(NUM_FEATURES)+FEAT_W+$clog2(NODES_PER_TREE)+2  {is_leaf, feat_idx, threshold, child, class}, MSB first
- cfg_err  out  1  one-cycle pulse: write dropped because the engine was busy
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- final_action  out  2  0 NO_ACTION, 1 SCRUB, 2 REFRESH
- ml_vote  out  2  forest majority before override
- rule_override  out  1  expert rule decided final_action
- depth_err  out  1  at least one tree hit MAX_DEPTH without reaching a leaf

## Operation
- States: IDLE, WALK, VOTE, DONE.
- IDLE: in_ready=1. On in_valid: register features, tree=0, node=0, depth=0, clear counts; go to WALK.
- WALK: one node per cycle from the node memory (combinational read).
- Leaf node: counts[class]++ (class 3 counts as 0). Then tree++, node=0, depth=0.
- Internal node: go to child if features[feat_idx] <= threshold, else child+1 (wraps mod NODES_PER_TREE). feat_idx >= NUM_FEATURES reads as 0.
- depth==MAX_DEPTH-1 on a non-leaf: vote class 0, set depth_err, advance to next tree.
- After the last tree's vote, go to VOTE.
- VOTE, majority: 1 if c1>=c0 && c1>=c2; else 2 if c2>=c0 && c2>=c1; else 0. Count width $clog2(NUM_TREES+1).
- VOTE, expert rules on registered features:
  - SCRUB if max_row_hits>=ROW_HIT_TH, or unique_rows*RATIO_MUL < total_errors (product in FEAT_W+8 bits, no overflow).
  - Else REFRESH if error_rate_int>=RATE_TH and unique_cols>=COL_TH.
  - Else none.
- final_action = rule result if non-zero, else ml_vote. rule_override set accordingly. Register all outputs; go to DONE.
- DONE: out_valid=1, outputs stable. On out_ready go to IDLE; in_ready rises the next cycle (no same-cycle turnaround).
- cfg_we in IDLE writes the node memory.
- cfg_we outside IDLE is dropped and cfg_err pulses for one cycle.
- cfg_we and in_valid in the same IDLE cycle: the write lands first and the walk sees the new data.
- Node memory is not cleared by reset; software loads it after power-up.

## Timing
- Reset (rst_n low at a clock edge): state IDLE; in_ready=1 after reset; out_valid=0, final_action=0, ml_vote=0, rule_override=0, depth_err=0, cfg_err=0, counts=0.
- Reset mid-walk or in DONE aborts the transaction and drops the pending result.
- Latency: input handshake at cycle 0. WALK occupies cycles 1..N, where N = total nodes visited across all trees. VOTE is cycle N+1. out_valid rises at cycle N+2.
- Best case (every root a leaf): N=NUM_TREES. Worst case: N=NUM_TREES*MAX_DEPTH.
- Outputs hold indefinitely under out_ready=0.
- Throughput: one vector per N+3 cycles minimum.

## Test plan
- All 5 roots are leaves with class 1. Send a vector with all features 0, out_ready=1 -> out_valid at cycle 7; ml_vote=1, final_action=1, rule_override=0.
- Leaves vote 0,0,1,1,2 (tie). Features: unique_rows=10, total_errors=20 -> ml_vote=1, final_action=1 (tie-break to 1).
- Forest all class 0. max_row_hits=64 -> final_action=1, rule_override=1. Second case: error_rate_int=50, unique_cols=8, unique_rows=4, total_errors=20 -> 20 is not < 20, so final_action=2, rule_override=1.
- Tree 0 root is an internal node, feat 3, threshold 4, child 1. Node 1 is leaf class 2; node 2 is leaf class 0. Other trees are class-0 leaves. scrub_errors=4 -> ml_vote=0, N=6, out_valid at cycle 8. Repeat with threshold 3 -> path goes to node 2, still ml_vote=0.
- Self-loop: node 0 is internal with child 0, feature 0, threshold 0xFFFF -> visits node 0 every cycle. depth_err=1; that tree votes 0 after exactly MAX_DEPTH cycles.
- Hold out_ready=0 for 10 cycles -> outputs stable and in_ready=0. cfg_we during WALK -> cfg_err pulse, memory unchanged. rst_n low mid-WALK -> next cycle in_ready=1, out_valid=0.
